seq_multiplier: RTL and testbench

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/mult_pkg.sv | 12 +
 rtl/seq_mult_datapath.sv | 47 ++++
 rtl/seq_multiplier.sv | 132 +++++++++++++
 tb/tb_seq_multiplier.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mult_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mult_datapath.sv
// Shift-add datapath: one multiplier bit per step, LSB first, full-width accumulator.
module seq_mult_datapath
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   acc_next_c
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]    acc;

  // Accumulator value after the current multiplier bit is applied
  always_comb begin
    acc_next_c = acc;
    if (mplier[0]) begin
      acc_next_c = acc + mcand;
    end
  end

  // Operand latch on load, then shift multiplicand left / multiplier right per step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (load) begin
      mcand  <= PW'(a);
      mplier <= b;
      acc    <= '0;
    end else if (step) begin
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      acc    <= acc_next_c;
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential WIDTH-cycle multiplier with valid/ready handshakes on both sides.
// Optional two's-complement mode (tc port) enabled by defining SEQ_MULT_SIGNED_EN.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic                 tc,
`endif
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   P
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;
  logic             load;
  logic             step;
  logic [WIDTH-1:0] a_op;
  logic [WIDTH-1:0] b_op;
  logic [PW-1:0]    acc_next_c;
  logic [PW-1:0]    result_c;

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

`ifdef SEQ_MULT_SIGNED_EN
  logic neg;

  // Signed mode multiplies magnitudes; the sign is reapplied on the final bit
  always_comb begin
    a_op = A;
    b_op = B;
    if (tc && A[WIDTH-1]) a_op = -A;
    if (tc && B[WIDTH-1]) b_op = -B;
  end

  // Result sign captured together with the operands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg <= 1'b0;
    end else if (load) begin
      neg <= tc && (A[WIDTH-1] ^ B[WIDTH-1]);
    end
  end

  // Conditional negation of the finished magnitude product
  always_comb begin
    result_c = acc_next_c;
    if (neg) result_c = -acc_next_c;
  end
`else
  // Unsigned only: operands pass straight through
  always_comb begin
    a_op     = A;
    b_op     = B;
    result_c = acc_next_c;
  end
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = BUSY;
      BUSY:    if (last_bit) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake and datapath control decoded from state
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    load      = (state == IDLE) && in_valid;
    step      = (state == BUSY);
  end

  // Bit counter: cleared on acceptance, advanced once per BUSY cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Product register, updated only on the edge that processes the last bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      P <= '0;
    end else if (step && last_bit) begin
      P <= result_c;
    end
  end

  seq_mult_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .step       (step),
    .a          (a_op),
    .b          (b_op),
    .acc_next_c (acc_next_c)
  );

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier at WIDTH=8.
// Signed vectors run when SEQ_MULT_SIGNED_EN is defined.
module tb_seq_multiplier;

  localparam int unsigned W = 8;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          out_valid;
  logic          out_ready;
  logic [2*W-1:0] P;
`ifdef SEQ_MULT_SIGNED_EN
  logic          tc;
`endif

  int unsigned checks;
  int unsigned failures;
  int unsigned cyc;

  logic [2*W-1:0] exp_q[$];
  int unsigned    cyc_q[$];

  seq_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef SEQ_MULT_SIGNED_EN
    .tc        (tc),
`endif
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .P         (P)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Present operands, wait for acceptance, push the expected product.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] exp, input bit junk,
                       output int unsigned acc_cyc);
    bit ok;
    ok = 1'b0;
    acc_cyc = 0;
    @(negedge clk);
    in_valid = 1'b1;
    A = a;
    B = b;
    for (int n = 0; n < 200; n++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: in_ready stayed 0 for A=%0d B=%0d", a, b);
      in_valid = 1'b0;
    end else begin
      acc_cyc = cyc + 1;
      exp_q.push_back(exp);
      cyc_q.push_back(acc_cyc);
      @(negedge clk);
      if (junk) begin
        // Garbage on the inputs throughout BUSY and across the DONE edge
        for (int i = 0; i < int'(W); i++) begin
          in_valid = 1'($urandom_range(0, 1));
          A = W'($urandom);
          B = W'($urandom);
          @(negedge clk);
        end
      end
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d results still pending", exp_q.size());
    end
  endtask

  // Monitor: every rising out_valid must match the oldest accepted operation.
  initial begin
    logic ov_prev;
    logic [2*W-1:0] e;
    int unsigned c;
    ov_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ov_prev = 1'b0;
      end else begin
        if (out_valid && !ov_prev) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result: P=%0d with no pending operation", P);
          end else begin
            e = exp_q.pop_front();
            c = cyc_q.pop_front();
            check("product", 32'(P), 32'(e));
            check("latency", cyc - c, W);
          end
        end
        ov_prev = out_valid;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned t0;
    int unsigned t1;
    bit seen;
    cyc       = 0;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    A         = '0;
    B         = '0;
    out_ready = 1'b1;
`ifdef SEQ_MULT_SIGNED_EN
    tc        = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 1);
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_P", 32'(P), 0);
    rst = 1'b0;

    // Back-to-back operations: minimum initiation interval is W+2
    issue(8'd5, 8'd10, 16'd50, 1'b0, t0);
    issue(8'd255, 8'd255, 16'd65025, 1'b0, t1);
    check("init_interval", t1 - t0, W + 2);
    issue(8'd0, 8'd200, 16'd0, 1'b0, t0);
    issue(8'd1, 8'd0, 16'd0, 1'b0, t0);
    issue(8'd128, 8'd2, 16'd256, 1'b0, t0);
    issue(8'd17, 8'd13, 16'd221, 1'b1, t0);
    issue(8'd3, 8'd85, 16'd255, 1'b1, t0);
    drain();

    // Consumer stall: P and handshakes hold until out_ready
    out_ready = 1'b0;
    issue(8'd15, 8'd15, 16'd225, 1'b0, t0);
    seen = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("stall_out_valid_seen", 32'(seen), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_P", 32'(P), 225);
      check("stall_out_valid", 32'(out_valid), 1);
      check("stall_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("release_out_valid", 32'(out_valid), 0);
    check("release_in_ready", 32'(in_ready), 1);

    // Reset in the middle of BUSY discards the operation
    issue(8'd100, 8'd2, 16'd200, 1'b0, t0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_in_ready", 32'(in_ready), 1);
    check("midrst_P", 32'(P), 0);
    exp_q.delete();
    cyc_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (2 * W) @(negedge clk);
    check("post_rst_no_result", 32'(out_valid), 0);
    issue(8'd255, 8'd1, 16'd255, 1'b0, t0);
    drain();

`ifdef SEQ_MULT_SIGNED_EN
    tc = 1'b1;
    issue(8'hFF, 8'hFF, 16'd1, 1'b0, t0);
    issue(8'h80, 8'h80, 16'd16384, 1'b0, t0);
    issue(8'hFD, 8'd7, 16'hFFEB, 1'b0, t0);
    issue(8'd7, 8'hFD, 16'hFFEB, 1'b0, t0);
    tc = 1'b0;
    issue(8'hFF, 8'hFF, 16'd65025, 1'b0, t0);
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
